// File: rtl/spi_regbank.sv
// spi_regbank: control/status register bank behind an SPI slave front end.
// Define SPI_REGBANK_STAT_IRQ_EN to add sticky status, irq-enable and o_irq.
module spi_regbank #(
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int N_CTRL = 3,
  parameter int N_STAT = 3,
  parameter logic [N_CTRL*DW-1:0] CTRL_RST =
    (N_CTRL*DW)'(16'h0100)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [AW-1:0]        i_addr,
  input  logic [DW-1:0]        i_wdata,
  input  logic                 i_wr,
  input  logic                 i_rd,
  output logic [DW-1:0]        o_rdata,
  output logic                 o_rvalid,
  output logic                 o_err,
  input  logic [N_STAT-1:0]    i_stat,
  output logic [N_CTRL*DW-1:0] o_ctrl,
  output logic                 o_irq
);

  localparam logic [AW-1:0] A_STAT = AW'(2 * N_CTRL);

  logic [DW-1:0]     ctrl [N_CTRL];
  logic [N_CTRL-1:0] hit_ctrl;
  logic              hit_stat;
  logic              mapped;
  logic              rd_en;
  logic [DW-1:0]     rd_mux;
  logic [N_STAT-1:0] sync1;
  logic [N_STAT-1:0] sync2;

`ifdef SPI_REGBANK_STAT_IRQ_EN
  localparam logic [AW-1:0] A_STK = AW'(2 * N_CTRL + 2);
  localparam logic [AW-1:0] A_IEN = AW'(2 * N_CTRL + 4);

  logic              hit_stk;
  logic              hit_ien;
  logic [N_STAT-1:0] stat_d;
  logic [N_STAT-1:0] sticky;
  logic [N_STAT-1:0] ien;
  logic [N_STAT-1:0] rise;
  logic [N_STAT-1:0] clr;

  assign hit_stk = (i_addr == A_STK);
  assign hit_ien = (i_addr == A_IEN);
  assign mapped  = |hit_ctrl | hit_stat | hit_stk | hit_ien;
`else
  assign mapped  = |hit_ctrl | hit_stat;
`endif

  // Full-width address decode of the control registers.
  always_comb begin
    hit_ctrl = '0;
    for (int k = 0; k < N_CTRL; k++)
      hit_ctrl[k] = (i_addr == AW'(2 * k));
  end

  assign hit_stat = (i_addr == A_STAT);
  // A write in the same cycle wins; the read is dropped.
  assign rd_en    = i_rd & ~i_wr;

  // Read data select; unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_CTRL; k++)
      if (hit_ctrl[k]) rd_mux = ctrl[k];
    if (hit_stat) rd_mux = DW'(sync2);
`ifdef SPI_REGBANK_STAT_IRQ_EN
    if (hit_stk) rd_mux = DW'(sticky);
    if (hit_ien) rd_mux = DW'(ien);
`endif
  end

  // Two-flop synchronizer for the asynchronous status inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_stat;
      sync2 <= sync1;
    end
  end

  // Control registers: full-width write on a decoded hit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N_CTRL; k++)
        ctrl[k] <= CTRL_RST[k*DW +: DW];
    end else begin
      for (int k = 0; k < N_CTRL; k++)
        if (i_wr && hit_ctrl[k]) ctrl[k] <= i_wdata;
    end
  end

  for (genvar k = 0; k < N_CTRL; k++) begin : g_out
    assign o_ctrl[k*DW +: DW] = ctrl[k];
  end

  // Read response and error pulse, one cycle after the strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_rvalid <= rd_en;
      o_err    <= (i_wr & i_rd) | ((i_wr | i_rd) & ~mapped);
      if (rd_en) o_rdata <= rd_mux;
    end
  end

`ifdef SPI_REGBANK_STAT_IRQ_EN
  assign rise = sync2 & ~stat_d;
  assign clr  = (i_wr && hit_stk) ? i_wdata[N_STAT-1:0] : '0;

  // Sticky edge capture (set beats W1C), enable and registered irq.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_d <= '0;
      sticky <= '0;
      ien    <= '0;
      o_irq  <= 1'b0;
    end else begin
      stat_d <= sync2;
      sticky <= (sticky & ~clr) | rise;
      if (i_wr && hit_ien) ien <= i_wdata[N_STAT-1:0];
      o_irq  <= |(sticky & ien);
    end
  end
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regbank.sv
// tb_spi_regbank: random register traffic checked against a
// behavioural model of the register map, plus directed cases.
module tb_spi_regbank;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NC = 3;
  localparam int NS = 3;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [AW-1:0]     i_addr = '0;
  logic [DW-1:0]     i_wdata = '0;
  logic              i_wr = 1'b0;
  logic              i_rd = 1'b0;
  logic [DW-1:0]     o_rdata;
  logic              o_rvalid;
  logic              o_err;
  logic [NS-1:0]     i_stat = '0;
  logic [NC*DW-1:0]  o_ctrl;
  logic              o_irq;

  always #5 clk = ~clk;

  spi_regbank dut (
    .clk(clk),
    .rstn(rstn),
    .i_addr(i_addr),
    .i_wdata(i_wdata),
    .i_wr(i_wr),
    .i_rd(i_rd),
    .o_rdata(o_rdata),
    .o_rvalid(o_rvalid),
    .o_err(o_err),
    .i_stat(i_stat),
    .o_ctrl(o_ctrl),
    .o_irq(o_irq)
  );

  int n_run = 0;
  int n_fail = 0;

  logic [DW-1:0] m_ctrl [NC];
  logic [DW-1:0] m_rdata;
  logic          m_rvalid;
  logic          m_err;
  logic          m_irq;
  logic [NS-1:0] m_stk;
  logic [NS-1:0] m_ien;
  // i_stat as sampled 1, 2 and 3 edges ago
  logic [NS-1:0] hist [3];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int n_regs();
`ifdef SPI_REGBANK_STAT_IRQ_EN
    return NC + 3;
`else
    return NC + 1;
`endif
  endfunction

  function automatic bit mapped(input logic [AW-1:0] a);
    return (a % 2 == 0) && (int'(a / 2) < n_regs());
  endfunction

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    int idx;
    idx = int'(a / 2);
    if (!mapped(a)) return '0;
    if (idx < NC) return m_ctrl[idx];
    if (idx == NC) return DW'(hist[1]);
    if (idx == NC + 1) return DW'(m_stk);
    return DW'(m_ien);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_ctrl[k] = '0;
    m_ctrl[0] = 16'h0100;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    m_irq    = 1'b0;
    m_stk    = '0;
    m_ien    = '0;
    for (int k = 0; k < 3; k++) hist[k] = '0;
  endtask

  task automatic model_edge();
    int idx;
    bit hit;
    idx = int'(i_addr / 2);
    hit = mapped(i_addr);
`ifdef SPI_REGBANK_STAT_IRQ_EN
    m_irq = |(m_stk & m_ien);
`endif
    m_rvalid = i_rd && !i_wr;
    m_err = (i_wr && i_rd) || ((i_wr || i_rd) && !hit);
    if (m_rvalid) m_rdata = rd_val(i_addr);
    if (i_wr && hit && idx < NC) m_ctrl[idx] = i_wdata;
`ifdef SPI_REGBANK_STAT_IRQ_EN
    begin
      logic [NS-1:0] clr;
      clr = (i_wr && hit && idx == NC + 1) ? i_wdata[NS-1:0] : '0;
      m_stk = (m_stk & ~clr) | (hist[1] & ~hist[2]);
      if (i_wr && hit && idx == NC + 2) m_ien = i_wdata[NS-1:0];
    end
`endif
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = i_stat;
  endtask

  task automatic cmp_all();
    logic [NC*DW-1:0] ec;
    for (int k = 0; k < NC; k++) ec[k*DW +: DW] = m_ctrl[k];
    check("rvalid", 64'(o_rvalid), 64'(m_rvalid));
    check("err", 64'(o_err), 64'(m_err));
    check("rdata", 64'(o_rdata), 64'(m_rdata));
    check("ctrl", 64'(o_ctrl), 64'(ec));
    check("irq", 64'(o_irq), 64'(m_irq));
  endtask

  task automatic cyc(input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic wr, input logic rd);
    i_addr = a;
    i_wdata = wd;
    i_wr = wr;
    i_rd = rd;
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
    i_wr = 1'b0;
    i_rd = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    i_wr = 1'b0;
    i_rd = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rvalid", 64'(o_rvalid), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_rdata", 64'(o_rdata), 64'd0);
    check("rst_ctrl", 64'(o_ctrl), 64'h0000_0000_0100);
    check("rst_irq", 64'(o_irq), 64'd0);
    rstn = 1'b1;

    cyc(16'd0, '0, 1'b0, 1'b1);
    check("r0", 64'(o_rdata), 64'h0100);
    check("r0_v", 64'(o_rvalid), 64'd1);
    cyc(16'd2, '0, 1'b0, 1'b1);
    check("r2", 64'(o_rdata), 64'h0000);
    cyc(16'd4, '0, 1'b0, 1'b1);
    check("r4", 64'(o_rdata), 64'h0000);
    check("r4_v", 64'(o_rvalid), 64'd1);

    cyc(16'd0, 16'h1234, 1'b1, 1'b0);
    check("w0_ctrl", 64'(o_ctrl[15:0]), 64'h1234);
    cyc(16'd0, '0, 1'b0, 1'b1);
    check("w0_rd", 64'(o_rdata), 64'h1234);

    i_stat = 3'b101;
    repeat (3) cyc(16'd0, '0, 1'b0, 1'b0);
    cyc(16'd6, '0, 1'b0, 1'b1);
    check("stat", 64'(o_rdata), 64'h0005);

    cyc(16'h0040, '0, 1'b0, 1'b1);
    check("unm_rd", 64'(o_rdata), 64'd0);
    check("unm_rd_e", 64'(o_err), 64'd1);
    check("unm_rd_v", 64'(o_rvalid), 64'd1);
    cyc(16'h0003, 16'hbeef, 1'b1, 1'b0);
    check("unm_wr_e", 64'(o_err), 64'd1);
    check("unm_wr_c", 64'(o_ctrl), 64'h0000_0000_1234);

    cyc(16'd6, 16'hffff, 1'b1, 1'b0);
    check("ro_wr_e", 64'(o_err), 64'd0);

    cyc(16'd2, 16'd1, 1'b1, 1'b1);
    check("col_c1", 64'(o_ctrl[31:16]), 64'd1);
    check("col_v", 64'(o_rvalid), 64'd0);
    check("col_e", 64'(o_err), 64'd1);

`ifdef SPI_REGBANK_STAT_IRQ_EN
    i_stat = '0;
    repeat (4) cyc(16'd0, '0, 1'b0, 1'b0);
    cyc(16'd8, 16'h7, 1'b1, 1'b0);
    cyc(16'd10, 16'h2, 1'b1, 1'b0);
    i_stat = 3'b010;
    repeat (5) cyc(16'd0, '0, 1'b0, 1'b0);
    cyc(16'd8, '0, 1'b0, 1'b1);
    check("stk", 64'(o_rdata), 64'h2);
    check("irq_on", 64'(o_irq), 64'd1);
    cyc(16'd8, 16'h2, 1'b1, 1'b0);
    repeat (2) cyc(16'd0, '0, 1'b0, 1'b0);
    check("irq_off", 64'(o_irq), 64'd0);
`endif

    i_addr = '0;
    i_rd = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    i_rd = 1'b0;
    #1;
    check("rst_rd_v", 64'(o_rvalid), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc(16'd0, '0, 1'b0, 1'b0);
    check("post_rst_v", 64'(o_rvalid), 64'd0);

    for (int n = 0; n < 800; n++) begin
      logic [AW-1:0] a;
      if ($urandom % 8 == 0) i_stat = NS'($urandom);
      if ($urandom % 4 != 0)
        a = AW'($urandom_range(0, 2 * NC + 6));
      else
        a = AW'($urandom);
      cyc(a, DW'($urandom), ($urandom % 4) == 0, ($urandom % 3) == 0);
      if (n == 400) begin
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
